cve2_multdiv_issue: RTL
=======================

// Module: cve2_multdiv_issue
// PURPOSE
//  Initiator side of the slow multiply/divide unit interface. Accepts one M-extension request from
//  the ID stage over a valid/ready handshake and latches its operands. Drives the unit's
//  enable/select/operand inputs until the unit signals done, then presents the result over a
//  valid/ready response channel. The response ready is what throttles the unit's final hold.
// PARAMETERS
//  TimeoutCycles  40  max cycles in BUSY before err_o pulses; diagnostic only, must exceed the worst-case division latency
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   reset, synchronous, active-high
//  req_valid_i        in   1   ID stage offers a request
//  req_ready_o        out  1   block can accept (IDLE only)
//  req_op_i           in   2   cve2_pkg::md_op_e (MULL/MULH/DIV/REM)
//  req_signed_i       in   2   signed mode: [0]=op A signed, [1]=op B signed
//  req_op_a_i         in   32  operand A
//  req_op_b_i         in   32  operand B
//  kill_i             in   1   flush: discard the in-flight or pending op
//  md_mult_en_o       out  1   dynamic mult enable to unit
//  md_div_en_o        out  1   dynamic div enable to unit
//  md_mult_sel_o      out  1   static mult select
//  md_div_sel_o       out  1   static div select
//  md_operator_o      out  2   latched operator
//  md_signed_mode_o   out  2   latched signed mode
//  md_op_a_o          out  32  latched operand A
//  md_op_b_o          out  32  latched operand B
//  md_ready_id_o      out  1   allows the unit to leave its final/hold state
//  md_valid_i         in   1   unit result valid
//  md_result_i        in   32  unit result
//  rsp_valid_o        out  1   result available to writeback
//  rsp_ready_i        in   1   writeback accepts result
//  rsp_data_o         out  32  result
//  err_o              out  1   one-cycle pulse on watchdog timeout
// BEHAVIOUR
//  Reset values: state IDLE, all outputs 0 except req_ready_o=1.
//  Operand registers reset to 0 and load only when a request is accepted.
//  FSM states: IDLE, BUSY, DRAIN (enum in package).
//  IDLE:
//   - req_ready_o=1. Enables, selects and md_ready_id_o are all 0.
//   - req_valid_i & ~kill_i: latch op/signed/A/B, go to BUSY at the next cycle.
//   - kill_i in the same cycle blocks acceptance.
//  BUSY:
//   - sel = (op is MULL/MULH) for mult, else div. The matching en=1; the other en and sel are 0.
//   - Latched operands are held stable for the whole operation; the unit reads them at start and at its sign-fix step.
//   - md_ready_id_o = rsp_ready_i; rsp_valid_o = md_valid_i; rsp_data_o = md_result_i.
//   - md_valid_i & rsp_ready_i: transfer done, go to IDLE.
//   - md_valid_i & ~rsp_ready_i: stay in BUSY; the unit holds and the result stays stable.
//   - kill_i (with no transfer in the same cycle): go to DRAIN.
//   - kill_i together with a transfer: the transfer completes, then IDLE.
//  DRAIN:
//   - The unit cannot be aborted mid-op, so it runs to completion.
//   - en/sel are kept as in BUSY, md_ready_id_o=1, rsp_valid_o=0.
//   - md_valid_i: go to IDLE and discard the result. Further kill_i is ignored.
//  Latency: accept at cycle N, en high from N+1; the first possible response is the cycle the unit raises valid.
//  Throughput: one op in flight. After a transfer, the next accept is at the earliest 1 cycle later (IDLE).
//  Watchdog:
//   - Counter cleared in IDLE, increments each cycle in BUSY/DRAIN, saturates.
//   - err_o pulses once when the count reaches TimeoutCycles. The FSM is unaffected.
//   - Counter width $clog2(TimeoutCycles+1).
//  rst_i mid-op: forces IDLE. The unit shares the reset domain and returns to its own idle state.
//  Illegal state encoding: go to IDLE.
// STRUCTURE
//  cve2_pkg: md_op_e (existing) and new md_issue_fsm_e {MD_ISSUE_IDLE, MD_ISSUE_BUSY, MD_ISSUE_DRAIN}.
//  Single module, no sub-modules. Bench instantiates it back-to-back with cve2_multdiv_slow.
// TESTING
//  - MULL: A=7, B=6 signed=00, rsp_ready_i=1 -> one rsp beat, data=42, then req_ready_o=1.
//  - MULH: A=0x8000_0000, B=0x8000_0000 signed=11 -> data=0x4000_0000. rsp_ready_i low 5 cycles -> rsp_valid_o held, data stable, single transfer.
//  - DIV: A=-20, B=3 signed=11 -> data=0xFFFF_FFFA (-6). REM same operands -> 0xFFFF_FFFE (-2).
//  - DIV by zero: A=5, B=0 -> data=0xFFFF_FFFF. REM by zero -> 5. No err_o.
//  - kill_i 3 cycles after a DIV accept -> DRAIN, no rsp_valid_o. Then IDLE, and a following MULL 3*3 returns 9.
//  - req_valid_i with kill_i in IDLE -> not accepted. rst_i during BUSY -> IDLE next cycle, outputs at reset values.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared multiply/divide types: operator encoding, issue FSM states and the latched request.
package cve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ISSUE_IDLE  = 2'b00,
    MD_ISSUE_BUSY  = 2'b01,
    MD_ISSUE_DRAIN = 2'b10
  } md_issue_fsm_e;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } md_req_t;

endpackage

// File: rtl/cve2_multdiv_issue.sv
// Issue side of the slow mult/div unit: latches one request, drives the unit until done,
// and hands the result to writeback over a valid/ready channel.
module cve2_multdiv_issue
  import cve2_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_signed_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        kill_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic        md_mult_sel_o,
  output logic        md_div_sel_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_ready_id_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        err_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] TimeoutCnt   = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] TimeoutCntM1 = CntW'(TimeoutCycles - 1);

  md_issue_fsm_e   state_q;
  md_req_t         req_q;
  logic [CntW-1:0] wdog_q;
  logic            err_q;

  logic busy, drain, active, is_mult;

  assign busy    = (state_q == MD_ISSUE_BUSY);
  assign drain   = (state_q == MD_ISSUE_DRAIN);
  assign active  = busy | drain;
  assign is_mult = (req_q.op == MD_OP_MULL) | (req_q.op == MD_OP_MULH);

  assign req_ready_o      = (state_q == MD_ISSUE_IDLE);
  assign md_mult_en_o     = active & is_mult;
  assign md_mult_sel_o    = active & is_mult;
  assign md_div_en_o      = active & ~is_mult;
  assign md_div_sel_o     = active & ~is_mult;
  assign md_operator_o    = req_q.op;
  assign md_signed_mode_o = req_q.signed_mode;
  assign md_op_a_o        = req_q.op_a;
  assign md_op_b_o        = req_q.op_b;
  // While draining a killed op nobody consumes the result, so let the unit finish freely.
  assign md_ready_id_o    = (busy & rsp_ready_i) | drain;
  assign rsp_valid_o      = busy & md_valid_i;
  assign rsp_data_o       = busy ? md_result_i : 32'd0;
  assign err_o            = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_ISSUE_IDLE;
      req_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_ISSUE_IDLE: begin
          if (req_valid_i && !kill_i) begin
            req_q   <= '{op: md_op_e'(req_op_i), signed_mode: req_signed_i,
                         op_a: req_op_a_i, op_b: req_op_b_i};
            state_q <= MD_ISSUE_BUSY;
          end
        end
        MD_ISSUE_BUSY: begin
          // A transfer in the same cycle as a kill still completes.
          if (md_valid_i && rsp_ready_i) state_q <= MD_ISSUE_IDLE;
          else if (kill_i)               state_q <= MD_ISSUE_DRAIN;
        end
        MD_ISSUE_DRAIN: begin
          if (md_valid_i) state_q <= MD_ISSUE_IDLE;
        end
        default: state_q <= MD_ISSUE_IDLE;
      endcase

      if (active) begin
        if (wdog_q != TimeoutCnt) wdog_q <= wdog_q + 1'b1;
        err_q <= (wdog_q == TimeoutCntM1);
      end else begin
        wdog_q <= '0;
        err_q  <= 1'b0;
      end
    end
  end

endmodule
